// File: rtl/fifo_if.sv
// rtl/fifo_if.sv - producer/consumer handshake bundle for the synchronous FIFO
interface fifo_if #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8
);
    logic                    wr_en;
    logic                    rd_en;
    logic [DATA_WIDTH-1:0]   data_in;
    logic [DATA_WIDTH-1:0]   data_out;
    logic                    full;
    logic                    empty;
    logic [$clog2(DEPTH):0]  count;

    modport master (
        output wr_en, rd_en, data_in,
        input  data_out, full, empty, count
    );

    modport slave (
        input  wr_en, rd_en, data_in,
        output data_out, full, empty, count
    );
endinterface

// File: rtl/fifo.sv
// rtl/fifo.sv - single-clock FIFO with registered read data and occupancy flags
module fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8
) (
    input  logic  clk,
    input  logic  rst,
    fifo_if.slave bus
);
    localparam int            AW      = $clog2(DEPTH);
    localparam logic [AW:0]   CNT_MAX = (AW+1)'(DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]         wptr_q, wptr_d;
    logic [AW-1:0]         rptr_q, rptr_d;
    logic [AW:0]           cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic                  full_w, empty_w;
    logic                  wr_ok, rd_ok;

    assign full_w  = (cnt_q == CNT_MAX);
    assign empty_w = (cnt_q == '0);

    // A write into a full FIFO is allowed when the head is popped on the same edge.
    assign wr_ok = bus.wr_en && (!full_w || bus.rd_en);
    assign rd_ok = bus.rd_en && !empty_w;

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        dout_d = dout_q;
        if (wr_ok) begin
            wptr_d = wptr_q + 1'b1;
        end
        if (rd_ok) begin
            rptr_d = rptr_q + 1'b1;
            dout_d = mem_q[rptr_q];
        end
        case ({wr_ok, rd_ok})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
            dout_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
            dout_q <= dout_d;
        end
    end

    // Storage is never cleared; occupancy alone decides which entries are live.
    always_ff @(posedge clk) begin
        if (!rst && wr_ok) begin
            mem_q[wptr_q] <= bus.data_in;
        end
    end

    assign bus.data_out = dout_q;
    assign bus.full     = full_w;
    assign bus.empty    = empty_w;
    assign bus.count    = cnt_q;
endmodule

// File: tb/tb_fifo.sv
// tb/tb_fifo.sv - randomized self-checking bench for fifo against a queue model
module tb_fifo;
    localparam int DW = 8;
    localparam int DP = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    fifo_if #(.DATA_WIDTH(DW), .DEPTH(DP)) bus ();

    fifo #(.DATA_WIDTH(DW), .DEPTH(DP)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    logic [DW-1:0] model_q [$];
    logic [DW-1:0] exp_dout;
    int n_vec = 0;
    int n_err = 0;

    // Drive one cycle at the falling edge, update the model at the rising edge,
    // and return at the next falling edge where outputs are sampled.
    task automatic step(input logic w, input logic r, input logic [DW-1:0] d, input logic rs);
        bit wo, ro;
        bus.wr_en   = w;
        bus.rd_en   = r;
        bus.data_in = d;
        rst         = rs;
        @(posedge clk);
        if (rs) begin
            model_q.delete();
            exp_dout = '0;
        end else begin
            ro = r && (model_q.size() > 0);
            wo = w && ((model_q.size() < DP) || r);
            if (ro) exp_dout = model_q.pop_front();
            if (wo) model_q.push_back(d);
        end
        @(negedge clk);
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
        rst       = 1'b0;
    endtask

    task automatic test_reset();
        step(1'b0, 1'b0, 8'h00, 1'b1);
        n_vec++; if (bus.empty !== 1'b1) begin n_err++; $display("FAIL reset_empty got %b exp 1", bus.empty); end
        n_vec++; if (bus.full !== 1'b0) begin n_err++; $display("FAIL reset_full got %b exp 0", bus.full); end
        n_vec++; if (bus.count !== 4'd0) begin n_err++; $display("FAIL reset_count got %0d exp 0", bus.count); end
        n_vec++; if (bus.data_out !== 8'h00) begin n_err++; $display("FAIL reset_dout got %h exp 00", bus.data_out); end
    endtask

    task automatic test_single();
        step(1'b1, 1'b0, 8'hA5, 1'b0);
        n_vec++; if (bus.count !== 4'd1) begin n_err++; $display("FAIL single_count got %0d exp 1", bus.count); end
        step(1'b0, 1'b1, 8'h00, 1'b0);
        n_vec++; if (bus.data_out !== 8'hA5) begin n_err++; $display("FAIL single_dout got %h exp a5", bus.data_out); end
        n_vec++; if (bus.empty !== 1'b1) begin n_err++; $display("FAIL single_empty got %b exp 1", bus.empty); end
    endtask

    task automatic test_fill();
        for (int i = 0; i < DP; i++) begin
            step(1'b1, 1'b0, 8'(i + 1), 1'b0);
            n_vec++; if (bus.count !== 4'(i + 1)) begin n_err++; $display("FAIL fill_count got %0d exp %0d", bus.count, i + 1); end
        end
        n_vec++; if (bus.full !== 1'b1) begin n_err++; $display("FAIL fill_full got %b exp 1", bus.full); end
        step(1'b1, 1'b0, 8'hFF, 1'b0);
        n_vec++; if (bus.count !== 4'd8 || bus.full !== 1'b1) begin n_err++; $display("FAIL overflow_ignored got cnt %0d full %b exp 8 1", bus.count, bus.full); end
        for (int i = 0; i < DP; i++) begin
            step(1'b0, 1'b1, 8'h00, 1'b0);
            n_vec++; if (bus.data_out !== 8'(i + 1)) begin n_err++; $display("FAIL drain_dout got %h exp %h", bus.data_out, 8'(i + 1)); end
        end
        n_vec++; if (bus.empty !== 1'b1) begin n_err++; $display("FAIL drain_empty got %b exp 1", bus.empty); end
    endtask

    task automatic test_underflow();
        logic [DW-1:0] prev;
        prev = exp_dout;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 8'($urandom), 1'b0);
            n_vec++; if (bus.data_out !== prev) begin n_err++; $display("FAIL underflow_dout got %h exp %h", bus.data_out, prev); end
            n_vec++; if (bus.count !== 4'd0 || bus.empty !== 1'b1) begin n_err++; $display("FAIL underflow_cnt got %0d empty %b exp 0 1", bus.count, bus.empty); end
        end
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'($urandom), 1'b0);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b1, 8'h00, 1'b0);
            n_vec++; if (bus.data_out !== exp_dout) begin n_err++; $display("FAIL wrap_pre_dout got %h exp %h", bus.data_out, exp_dout); end
        end
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 8'(8'h10 + i), 1'b0);
        n_vec++; if (bus.count !== 4'd6) begin n_err++; $display("FAIL wrap_count got %0d exp 6", bus.count); end
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 1'b1, 8'h00, 1'b0);
            n_vec++; if (bus.data_out !== 8'(8'h10 + i)) begin n_err++; $display("FAIL wrap_dout got %h exp %h", bus.data_out, 8'(8'h10 + i)); end
        end
        n_vec++; if (bus.empty !== 1'b1) begin n_err++; $display("FAIL wrap_empty got %b exp 1", bus.empty); end
    endtask

    task automatic test_simul_reset();
        logic [DW-1:0] oldest;
        for (int i = 0; i < DP; i++) step(1'b1, 1'b0, 8'($urandom), 1'b0);
        oldest = model_q[0];
        step(1'b1, 1'b1, 8'h77, 1'b0);
        n_vec++; if (bus.count !== 4'd8) begin n_err++; $display("FAIL simul_count got %0d exp 8", bus.count); end
        n_vec++; if (bus.data_out !== oldest) begin n_err++; $display("FAIL simul_dout got %h exp %h", bus.data_out, oldest); end
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 8'h00, 1'b0);
        n_vec++; if (bus.count !== 4'd3) begin n_err++; $display("FAIL pre_rst_count got %0d exp 3", bus.count); end
        step(1'b0, 1'b0, 8'h00, 1'b1);
        n_vec++; if (bus.count !== 4'd0 || bus.empty !== 1'b1) begin n_err++; $display("FAIL midrst_cnt got %0d empty %b exp 0 1", bus.count, bus.empty); end
        n_vec++; if (bus.data_out !== 8'h00) begin n_err++; $display("FAIL midrst_dout got %h exp 00", bus.data_out); end
        step(1'b0, 1'b1, 8'h00, 1'b0);
        n_vec++; if (bus.data_out !== 8'h00 || bus.count !== 4'd0) begin n_err++; $display("FAIL post_rst_read got %h cnt %0d exp 00 0", bus.data_out, bus.count); end
    endtask

    task automatic test_random();
        logic w, r, rs;
        for (int i = 0; i < 400; i++) begin
            w  = ($urandom_range(0, 99) < 55);
            r  = ($urandom_range(0, 99) < 45);
            rs = ($urandom_range(0, 99) < 2);
            step(w, r, 8'($urandom), rs);
            n_vec++; if (bus.count !== 4'(model_q.size())) begin n_err++; $display("FAIL rand_count got %0d exp %0d", bus.count, model_q.size()); end
            n_vec++; if (bus.full !== (model_q.size() == DP)) begin n_err++; $display("FAIL rand_full got %b exp %b", bus.full, model_q.size() == DP); end
            n_vec++; if (bus.empty !== (model_q.size() == 0)) begin n_err++; $display("FAIL rand_empty got %b exp %b", bus.empty, model_q.size() == 0); end
            n_vec++; if (bus.data_out !== exp_dout) begin n_err++; $display("FAIL rand_dout got %h exp %h", bus.data_out, exp_dout); end
        end
    endtask

    initial begin
        bus.wr_en   = 1'b0;
        bus.rd_en   = 1'b0;
        bus.data_in = '0;
        exp_dout    = '0;
        test_reset();
        test_single();
        test_fill();
        test_underflow();
        test_wrap();
        test_simul_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
